paddle_position_controller: RTL and testbench

//   Owns both paddle Y positions consumed by the paddle renderer.

---
 rtl/paddle_position_controller.sv | 129 ++++++++++++
 tb/tb_paddle_position_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/paddle_position_controller.sv
// Paddle Y position owner: synchronised buttons, per-frame update sequencer,
// optional AI tracking for paddle 2, positions clamped to the screen.
module paddle_position_controller #(
  parameter int paddle_height = 50,
  parameter int screen_height = 480,
  parameter int paddle_speed  = 4,
  parameter int ai_speed      = 2,
  parameter int ai_deadzone   = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_frame_tick,
  input  logic       i_p1_up,
  input  logic       i_p1_down,
  input  logic       i_p2_up,
  input  logic       i_p2_down,
  input  logic       i_p2_ai,
  input  logic [9:0] i_ball_y,
  output logic [9:0] o_y_paddle1_pos,
  output logic [9:0] o_y_paddle2_pos,
  output logic       o_update_done
);

  localparam logic [10:0] MaxPos = 11'(screen_height - paddle_height);
  localparam logic [9:0]  RstPos = 10'((screen_height - paddle_height) / 2);
  localparam logic [10:0] Half   = 11'(paddle_height / 2);
  localparam logic [10:0] HumStp = 11'(paddle_speed);
  localparam logic [10:0] AiStp  = 11'(ai_speed);
  localparam logic [10:0] Dz     = 11'(ai_deadzone);

  typedef enum logic [1:0] {
    IDLE,
    UPD_P1,
    UPD_P2,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] pos1_q, pos1_d;
  logic [9:0] pos2_q, pos2_d;
  logic       done_q, done_d;
  logic       tick_q, tick_d;
  logic [3:0] sync1_q, sync2_q;

  logic       p1_up, p1_dn, p2_up, p2_dn;
  logic [10:0] ball, centre;
  logic       ai_up, ai_dn;

  function automatic logic [9:0] move(
    input logic [9:0]  pos,
    input logic        up,
    input logic        dn,
    input logic [10:0] s
  );
    logic [10:0] p;
    logic [10:0] r;
    p = {1'b0, pos};
    r = p;
    if (up && !dn) begin
      r = (p < s) ? 11'd0 : p - s;
    end else if (dn && !up) begin
      r = (p + s > MaxPos) ? MaxPos : p + s;
    end
    return r[9:0];
  endfunction

  assign p1_up = sync2_q[0];
  assign p1_dn = sync2_q[1];
  assign p2_up = sync2_q[2];
  assign p2_dn = sync2_q[3];

  assign ball   = {1'b0, i_ball_y};
  assign centre = {1'b0, pos2_q} + Half;
  assign ai_up  = (ball + Dz) < centre;
  assign ai_dn  = ball > (centre + Dz);

  // A tick is only captured while idle; one already pending blocks another.
  always_comb begin
    state_d = state_q;
    pos1_d  = pos1_q;
    pos2_d  = pos2_q;
    done_d  = 1'b0;
    tick_d  = i_frame_tick && (state_q == IDLE) && !tick_q;
    unique case (state_q)
      IDLE: begin
        if (tick_q) state_d = UPD_P1;
      end
      UPD_P1: begin
        pos1_d  = move(pos1_q, p1_up, p1_dn, HumStp);
        state_d = UPD_P2;
      end
      UPD_P2: begin
        if (i_p2_ai) pos2_d = move(pos2_q, ai_up, ai_dn, AiStp);
        else         pos2_d = move(pos2_q, p2_up, p2_dn, HumStp);
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      pos1_q  <= RstPos;
      pos2_q  <= RstPos;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      pos1_q  <= pos1_d;
      pos2_q  <= pos2_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
      sync1_q <= {i_p2_down, i_p2_up, i_p1_down, i_p1_up};
      sync2_q <= sync1_q;
    end
  end

  assign o_y_paddle1_pos = pos1_q;
  assign o_y_paddle2_pos = pos2_q;
  assign o_update_done   = done_q;

endmodule

// File: tb/tb_paddle_position_controller.sv
// Directed bench for paddle_position_controller: frame latency, clamping,
// AI tracking, dropped ticks and mid-sequence reset.
module tb_paddle_position_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       p1u = 1'b0, p1d = 1'b0, p2u = 1'b0, p2d = 1'b0;
  logic       ai = 1'b0;
  logic [9:0] ball = '0;
  logic [9:0] pos1, pos2;
  logic       done;

  int n_run = 0;
  int n_fail = 0;
  logic [9:0] m1 = 10'd215;
  logic [9:0] m2 = 10'd215;

  always #5 clk = ~clk;

  paddle_position_controller dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_frame_tick    (tick),
    .i_p1_up         (p1u),
    .i_p1_down       (p1d),
    .i_p2_up         (p2u),
    .i_p2_down       (p2d),
    .i_p2_ai         (ai),
    .i_ball_y        (ball),
    .o_y_paddle1_pos (pos1),
    .o_y_paddle2_pos (pos2),
    .o_update_done   (done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    m1 = 10'd215;
    m2 = 10'd215;
  endtask

  // Called 1ns after a rising edge with the sequencer idle.
  task automatic frame(input logic [9:0] e1, input logic [9:0] e2);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    check("pos1_n1", pos1, m1);
    step(1);
    check("pos1_n2", pos1, e1);
    check("pos2_n2", pos2, m2);
    check("done_n2", done, 0);
    step(1);
    check("pos2_n3", pos2, e2);
    check("done_n3", done, 1);
    step(1);
    check("done_n4", done, 0);
    step(2);
    m1 = e1;
    m2 = e2;
  endtask

  initial begin
    int pulses;
    step(3);
    check("rst_pos1", pos1, 215);
    check("rst_pos2", pos2, 215);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step(3);

    // no buttons
    for (int i = 0; i < 3; i++) frame(10'd215, 10'd215);

    // p1 up to the top, no wrap
    p1u = 1'b1;
    step(3);
    for (int i = 0; i < 60; i++)
      frame((m1 < 10'd4) ? 10'd0 : m1 - 10'd4, m2);
    check("p1_top", pos1, 0);
    p1u = 1'b0;

    // p2 down to the bottom clamp
    apply_reset();
    p2d = 1'b1;
    step(3);
    for (int i = 0; i < 60; i++)
      frame(m1, (m2 + 10'd4 > 10'd430) ? 10'd430 : m2 + 10'd4);
    check("p2_bottom", pos2, 430);
    p2d = 1'b0;

    // both p1 buttons
    apply_reset();
    p1u = 1'b1;
    p1d = 1'b1;
    step(3);
    for (int i = 0; i < 5; i++) frame(10'd215, 10'd215);
    p1u = 1'b0;
    p1d = 1'b0;

    // AI tracks ball up, buttons ignored
    apply_reset();
    ai = 1'b1;
    ball = 10'd100;
    p2d = 1'b1;
    step(3);
    for (int i = 0; i < 80; i++)
      frame(m1, (m2 + 10'd25 > 10'd104) ? m2 - 10'd2 : m2);
    check("ai_stop", pos2, 79);
    p2d = 1'b0;
    apply_reset();
    ball = 10'd240;
    step(3);
    frame(10'd215, 10'd215);
    frame(10'd215, 10'd215);
    ball = 10'd250;
    frame(10'd215, 10'd217);
    ball = 10'd244;
    frame(10'd215, 10'd217);
    ai = 1'b0;

    // reset while paddle 2 is being updated
    apply_reset();
    p1u = 1'b1;
    p2d = 1'b1;
    step(3);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(2);
    check("mid_pos1", pos1, 211);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("abort_pos1", pos1, 215);
    check("abort_pos2", pos2, 215);
    check("abort_done", done, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (done) pulses++;
    end
    check("abort_pulses", pulses, 0);
    check("abort_hold1", pos1, 215);

    // extra ticks during a frame are dropped
    step(3);
    tick = 1'b1;
    step(3);
    tick = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      step(1);
    end
    check("drop_pulses", pulses, 1);
    check("drop_pos1", pos1, 211);
    check("drop_pos2", pos2, 219);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
